// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// md_pkg : shared op codes, FSM encoding and default latencies for the MD unit
// Revision: 1.0
// ============================================================================
package md_pkg;

    localparam logic [3:0] MD_MULT  = 4'h0;
    localparam logic [3:0] MD_DIV   = 4'h1;
    localparam logic [3:0] MD_MULTU = 4'h2;
    localparam logic [3:0] MD_DIVU  = 4'h3;
    localparam logic [3:0] MD_MTHI  = 4'h4;
    localparam logic [3:0] MD_MTLO  = 4'h5;
    localparam logic [3:0] MD_MFHI  = 4'h6;
    localparam logic [3:0] MD_MFLO  = 4'h7;
    localparam logic [3:0] MD_NONE  = 4'hF;

    typedef logic [1:0] md_state_t;
    localparam md_state_t ST_IDLE   = 2'd0;
    localparam md_state_t ST_LAUNCH = 2'd1;
    localparam md_state_t ST_RUN    = 2'd2;
    localparam md_state_t ST_ZERO   = 2'd3;

    localparam int MD_MUL_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF = 10;

    function automatic logic md_is_arith(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_hilo_file.sv
`default_nettype none
// ============================================================================
// md_hilo_file : architectural HI/LO plus one-deep rollback shadow
// Revision: 1.0
// ============================================================================
module md_hilo_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] hi_wdata_i,
    input  logic [31:0] lo_wdata_i,
    input  logic        snap_i,
    input  logic        restore_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

    // Restore dominates; a snapshot taken with a write captures the pre-write value.
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        if (restore_i) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
        end else begin
            if (snap_i) begin
                sh_hi_d = hi_q;
                sh_lo_d = lo_q;
            end
            if (hi_we_i) hi_d = hi_wdata_i;
            if (lo_we_i) lo_d = lo_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// md_issue_ctrl : issue/sequencing FSM for the multicycle multiply/divide unit
// Revision: 1.0
// ============================================================================
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT_DEF,
    parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid_i,
    input  logic [3:0]  op_code_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    input  logic        flush_i,
    input  logic        flush_md_i,
    output logic        stall_e_o,
    output logic [31:0] mf_data_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        dp_start_o,
    output logic [1:0]  dp_op_o,
    output logic [31:0] dp_a_o,
    output logic [31:0] dp_b_o,
    output logic        dp_abort_o,
    input  logic        dp_done_i,
    input  logic [63:0] dp_result_i
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [31:0]       a_q, a_d, b_q, b_d;

    logic        accept, kill;
    logic        hl_hi_we, hl_lo_we, hl_snap, hl_restore;
    logic [31:0] hl_hi_wd, hl_lo_wd;

    assign busy_o     = (state_q != ST_IDLE);
    assign stall_e_o  = op_valid_i & (op_code_i <= MD_MFLO) & busy_o;
    assign accept     = op_valid_i & ~stall_e_o & ~flush_i;
    assign kill       = flush_i & flush_md_i;
    assign dp_start_o = (state_q == ST_LAUNCH);
    assign dp_abort_o = kill & ((state_q == ST_LAUNCH) | (state_q == ST_RUN));
    assign dp_op_o    = op_q;
    assign dp_a_o     = a_q;
    assign dp_b_o     = b_q;
    assign mf_data_o  = (op_code_i == MD_MFLO) ? lo_o : hi_o;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        hl_hi_we   = 1'b0;
        hl_lo_we   = 1'b0;
        hl_hi_wd   = rs_val_i;
        hl_lo_wd   = rs_val_i;
        hl_snap    = 1'b0;
        hl_restore = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (md_is_arith(op_code_i)) begin
                        op_d    = op_code_i[1:0];
                        a_d     = rs_val_i;
                        b_d     = rt_val_i;
                        hl_snap = 1'b1;
                        state_d = (op_code_i[0] && (rt_val_i == 32'd0)) ? ST_ZERO : ST_LAUNCH;
                    end else if (op_code_i == MD_MTHI) begin
                        hl_snap  = 1'b1;
                        hl_hi_we = 1'b1;
                    end else if (op_code_i == MD_MTLO) begin
                        hl_snap  = 1'b1;
                        hl_lo_we = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                // op_q[0] marks the divide class (DIV=1, DIVU=3)
                cnt_d   = op_q[0] ? DIV_LOAD : MUL_LOAD;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (dp_done_i) begin
                    hl_hi_we = 1'b1;
                    hl_lo_we = 1'b1;
                    hl_hi_wd = dp_result_i[63:32];
                    hl_lo_wd = dp_result_i[31:0];
                    state_d  = ST_IDLE;
                end
            end
            ST_ZERO: begin
                hl_hi_we = 1'b1;
                hl_lo_we = 1'b1;
                hl_hi_wd = 32'd0;
                hl_lo_wd = 32'd0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A flush of the last MD op beats any completion landing this cycle.
        if (kill) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            hl_restore = 1'b1;
            hl_hi_we   = 1'b0;
            hl_lo_we   = 1'b0;
            hl_snap    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    md_hilo_file u_hilo (
        .clk        (clk),
        .rst_n      (rst_n),
        .hi_we_i    (hl_hi_we),
        .lo_we_i    (hl_lo_we),
        .hi_wdata_i (hl_hi_wd),
        .lo_wdata_i (hl_lo_wd),
        .snap_i     (hl_snap),
        .restore_i  (hl_restore),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

endmodule
`default_nettype wire
